// File: rtl/issue_pkg.sv
// Shared definitions for the age-matrix issue selector.
//   - default slot / issue-port counts
//   - entry index and entry-mask types sized for the defaults
//   - popcount helper used for free-slot and issue counting
package issue_pkg;

    localparam int unsigned ENTRIES_DEF = 8;
    localparam int unsigned ISSUE_W_DEF = 2;
    localparam int unsigned IDX_W_DEF   = $clog2(ENTRIES_DEF);

    typedef logic [IDX_W_DEF-1:0]   entry_idx_t;
    typedef logic [ENTRIES_DEF-1:0] entry_mask_t;

    // Counts set bits of a mask of up to 64 entries (zero-extend narrower masks).
    function automatic int unsigned popcount(input logic [63:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < 64; i++) begin
            n += int'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/age_oldest_pick.sv
// Oldest-entry picker over an age matrix.
// Ports:
//   cand_i   candidate mask
//   older_i  flattened age matrix, bit i*N+j set => slot i is older than slot j
//   pick_o   one-hot candidate that no other candidate is older than
//   found_o  at least one candidate exists
module age_oldest_pick #(
    parameter int unsigned N = 8
) (
    input  logic [N-1:0]   cand_i,
    input  logic [N*N-1:0] older_i,
    output logic [N-1:0]   pick_o,
    output logic           found_o
);

    logic [N-1:0] blocked;

    always_comb begin
        blocked = '0;
        for (int j = 0; j < N; j++) begin
            for (int i = 0; i < N; i++) begin
                if (i != j && cand_i[i] && older_i[i*N + j]) begin
                    blocked[j] = 1'b1;
                end
            end
        end
    end

    assign pick_o  = cand_i & ~blocked;
    assign found_o = |cand_i;

endmodule

// File: rtl/age_matrix_issue.sv
// Oldest-first multi-port issue selector for a reservation station.
// Relative slot age is held in an age matrix; each cycle up to ISSUE_W ready
// slots are presented oldest first on the issue ports.
// Ports:
//   clk_i, reset_ni            clock, async active-low reset
//   alloc_valid_i/alloc_idx_i  allocate a slot (becomes youngest)
//   flush_i                    clear all slots at the next edge
//   entry_ready_i              per-slot operands-ready
//   issue_ready_i              per-port FU accept
//   issue_valid_o/issue_idx_o  per-port selected slot (packed IDX_W per port)
//   entry_sel_o                slots issued this cycle
//   free_o/free_cnt_o          free-slot mask and count
//   alloc_err_o                sticky: allocation to an occupied slot
// Optional build macro AGE_ISSUE_PERF_EN adds starve_cnt_o and issue_cnt_o.
module age_matrix_issue
    import issue_pkg::*;
#(
    parameter  int unsigned ENTRIES = ENTRIES_DEF,
    parameter  int unsigned ISSUE_W = ISSUE_W_DEF,
    localparam int unsigned IDX_W   = $clog2(ENTRIES)
) (
    input  logic                     clk_i,
    input  logic                     reset_ni,
    input  logic                     alloc_valid_i,
    input  logic [IDX_W-1:0]         alloc_idx_i,
    input  logic                     flush_i,
    input  logic [ENTRIES-1:0]       entry_ready_i,
    input  logic [ISSUE_W-1:0]       issue_ready_i,
    output logic [ISSUE_W-1:0]       issue_valid_o,
    output logic [ISSUE_W*IDX_W-1:0] issue_idx_o,
    output logic [ENTRIES-1:0]       entry_sel_o,
    output logic [ENTRIES-1:0]       free_o,
    output logic [IDX_W:0]           free_cnt_o,
`ifdef AGE_ISSUE_PERF_EN
    output logic [31:0]              starve_cnt_o,
    output logic [31:0]              issue_cnt_o,
`endif
    output logic                     alloc_err_o
);

    logic [ENTRIES-1:0]              valid_q, valid_d;
    logic [ENTRIES-1:0][ENTRIES-1:0] older_q, older_d;
    logic                            err_q, err_d;
    logic [ENTRIES*ENTRIES-1:0]      older_flat;

    logic [ISSUE_W-1:0][ENTRIES-1:0] avail;
    logic [ISSUE_W-1:0][ENTRIES-1:0] pick;
    logic [ENTRIES-1:0]              issued;
    logic [ENTRIES-1:0]              valid_keep;
    logic                            in_range, slot_busy, alloc_ok, alloc_bad;

    assign older_flat = older_q;

    // Each port sees the candidates left over after the older ports' picks,
    // independent of downstream readiness so a stalled port keeps its entry.
    for (genvar p = 0; p < ISSUE_W; p++) begin : g_port
        if (p == 0) begin : g_first
            assign avail[p] = valid_q & entry_ready_i;
        end else begin : g_next
            assign avail[p] = avail[p-1] & ~pick[p-1];
        end
        age_oldest_pick #(.N(ENTRIES)) u_pick (
            .cand_i  (avail[p]),
            .older_i (older_flat),
            .pick_o  (pick[p]),
            .found_o (issue_valid_o[p])
        );
    end

    always_comb begin
        issued      = '0;
        issue_idx_o = '0;
        for (int p = 0; p < ISSUE_W; p++) begin
            for (int e = 0; e < ENTRIES; e++) begin
                if (pick[p][e]) begin
                    issue_idx_o[p*IDX_W +: IDX_W] = IDX_W'(e);
                end
            end
            issued = issued | (pick[p] & {ENTRIES{issue_ready_i[p]}});
        end
    end

    assign entry_sel_o = issued;
    assign free_o      = ~valid_q;
    assign free_cnt_o  = (IDX_W+1)'(ENTRIES - popcount(64'(valid_q)));
    assign alloc_err_o = err_q;

    // A slot issuing this cycle counts as free for allocation.
    assign valid_keep = valid_q & ~issued;
    assign in_range   = 32'(alloc_idx_i) < ENTRIES;
    assign slot_busy  = in_range ? valid_keep[alloc_idx_i] : 1'b1;
    assign alloc_ok   = alloc_valid_i & ~flush_i & ~slot_busy;
    assign alloc_bad  = alloc_valid_i & ~flush_i & slot_busy;

    always_comb begin
        valid_d = valid_keep;
        older_d = older_q;
        err_d   = err_q | alloc_bad;
        if (flush_i) begin
            valid_d = '0;
            older_d = '0;
        end else if (alloc_ok) begin
            valid_d[alloc_idx_i] = 1'b1;
            // New occupant is younger than every surviving slot; stale bits
            // of free slots are masked by valid during selection.
            for (int i = 0; i < ENTRIES; i++) begin
                older_d[i][alloc_idx_i] = (IDX_W'(i) != alloc_idx_i) && valid_keep[i];
            end
            older_d[alloc_idx_i] = '0;
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            valid_q <= '0;
            older_q <= '0;
            err_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            older_q <= older_d;
            err_q   <= err_d;
        end
    end

`ifdef AGE_ISSUE_PERF_EN
    logic [ENTRIES-1:0] oldest;
    logic               any_valid;
    logic [31:0]        starve_q, starve_d, icnt_q, icnt_d;

    age_oldest_pick #(.N(ENTRIES)) u_oldest (
        .cand_i  (valid_q),
        .older_i (older_flat),
        .pick_o  (oldest),
        .found_o (any_valid)
    );

    always_comb begin
        starve_d = starve_q;
        icnt_d   = icnt_q + popcount(64'(issued));
        if (flush_i) begin
            starve_d = '0;
        end else if (any_valid && ((oldest & issued) == '0) && (starve_q != '1)) begin
            starve_d = starve_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            starve_q <= '0;
            icnt_q   <= '0;
        end else begin
            starve_q <= starve_d;
            icnt_q   <= icnt_d;
        end
    end

    assign starve_cnt_o = starve_q;
    assign issue_cnt_o  = icnt_q;
`endif

endmodule

// File: tb/tb_age_matrix_issue.sv
module tb_age_matrix_issue;

    localparam int N = 4;
    localparam int W = 2;

    logic       clk_i = 1'b0;
    logic       reset_ni;
    logic       alloc_valid_i;
    logic [1:0] alloc_idx_i;
    logic       flush_i;
    logic [3:0] entry_ready_i;
    logic [1:0] issue_ready_i;
    logic [1:0] issue_valid_o;
    logic [3:0] issue_idx_o;
    logic [3:0] entry_sel_o;
    logic [3:0] free_o;
    logic [2:0] free_cnt_o;
    logic       alloc_err_o;
    logic [31:0] starve_cnt_o;
    logic [31:0] issue_cnt_o;

    always #5 clk_i = ~clk_i;

    age_matrix_issue #(.ENTRIES(N), .ISSUE_W(W)) dut (
        .clk_i         (clk_i),
        .reset_ni      (reset_ni),
        .alloc_valid_i (alloc_valid_i),
        .alloc_idx_i   (alloc_idx_i),
        .flush_i       (flush_i),
        .entry_ready_i (entry_ready_i),
        .issue_ready_i (issue_ready_i),
        .issue_valid_o (issue_valid_o),
        .issue_idx_o   (issue_idx_o),
        .entry_sel_o   (entry_sel_o),
        .free_o        (free_o),
        .free_cnt_o    (free_cnt_o),
`ifdef AGE_ISSUE_PERF_EN
        .starve_cnt_o  (starve_cnt_o),
        .issue_cnt_o   (issue_cnt_o),
`endif
        .alloc_err_o   (alloc_err_o)
    );

`ifndef AGE_ISSUE_PERF_EN
    assign starve_cnt_o = '0;
    assign issue_cnt_o  = '0;
`endif

    typedef struct packed {
        logic [1:0]  iv;
        logic [3:0]  idx;
        logic [3:0]  sel;
        logic [3:0]  free;
        logic [2:0]  fcnt;
        logic        err;
        logic [31:0] starve;
        logic [31:0] icnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    // Reference model: occupied slots listed in allocation order, oldest first.
    int          age[$];
    bit          m_err;
    int unsigned m_starve;
    int unsigned m_icnt;

    function automatic bit in_age(input int s);
        foreach (age[i]) if (age[i] == s) return 1;
        return 0;
    endfunction

    task automatic model_clear();
        age.delete();
        m_err    = 0;
        m_starve = 0;
        m_icnt   = 0;
    endtask

    task automatic step(input bit av, input int ai, input bit fl,
                        input logic [3:0] er, input logic [1:0] ir, input bit rst = 0);
        exp_t e;
        int   cand[$];
        int   rest[$];
        @(posedge clk_i);
        #1;
        reset_ni      = rst ? 1'b0 : 1'b1;
        alloc_valid_i = av;
        alloc_idx_i   = 2'(ai);
        flush_i       = fl;
        entry_ready_i = er;
        issue_ready_i = ir;
        if (rst) model_clear();

        e = '0;
        foreach (age[i]) if (er[age[i]]) cand.push_back(age[i]);
        for (int p = 0; p < W; p++) begin
            if (p < cand.size()) begin
                e.iv[p] = 1'b1;
                e.idx[p*2 +: 2] = 2'(cand[p]);
                if (ir[p]) e.sel[cand[p]] = 1'b1;
            end
        end
        e.free = 4'hF;
        foreach (age[i]) e.free[age[i]] = 1'b0;
        e.fcnt   = 3'(N - age.size());
        e.err    = m_err;
        e.starve = m_starve;
        e.icnt   = m_icnt;
        exp_q.push_back(e);

        if (!rst) begin
            if (age.size() > 0 && !e.sel[age[0]] && m_starve != 32'hFFFF_FFFF) m_starve++;
            m_icnt += $countones(e.sel);
            foreach (age[i]) if (!e.sel[age[i]]) rest.push_back(age[i]);
            age = rest;
            if (fl) begin
                age.delete();
                m_starve = 0;
            end else if (av) begin
                if (in_age(ai)) m_err = 1;
                else age.push_back(ai);
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk_i);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("issue_valid", 32'(issue_valid_o), 32'(e.iv));
                chk("issue_idx",   32'(issue_idx_o),   32'(e.idx));
                chk("entry_sel",   32'(entry_sel_o),   32'(e.sel));
                chk("free",        32'(free_o),        32'(e.free));
                chk("free_cnt",    32'(free_cnt_o),    32'(e.fcnt));
                chk("alloc_err",   32'(alloc_err_o),   32'(e.err));
`ifdef AGE_ISSUE_PERF_EN
                chk("starve_cnt",  starve_cnt_o,       e.starve);
                chk("issue_cnt",   issue_cnt_o,        e.icnt);
`endif
            end
        end
    end

    initial begin : driver
        int ai;
        int frees[$];
        reset_ni = 0; alloc_valid_i = 0; alloc_idx_i = 0; flush_i = 0;
        entry_ready_i = 0; issue_ready_i = 0;
        model_clear();
        repeat (2) @(posedge clk_i);

        // Reset values, then three consecutive allocations.
        step(0, 0, 0, 4'b0000, 2'b11, 1);
        step(1, 0, 0, 4'b0000, 2'b11);
        step(1, 1, 0, 4'b0000, 2'b11);
        step(1, 2, 0, 4'b0000, 2'b11);
        step(0, 0, 0, 4'b0000, 2'b11);
        // Younger ready entries issue past a not-ready oldest.
        step(0, 0, 0, 4'b0110, 2'b11);
        step(0, 0, 0, 4'b0000, 2'b11);
        step(0, 0, 1, 4'b0000, 2'b00);
        // Alloc order 2,0,3; port 1 stalled holds its entry.
        step(1, 2, 0, 4'b0000, 2'b00);
        step(1, 0, 0, 4'b0000, 2'b00);
        step(1, 3, 0, 4'b0000, 2'b00);
        step(0, 0, 0, 4'b1111, 2'b01);
        step(0, 0, 0, 4'b1111, 2'b11);
        step(0, 0, 1, 4'b0000, 2'b00);
        // Issue and re-allocate slot 1 in the same cycle.
        step(1, 3, 0, 4'b0000, 2'b00);
        step(1, 1, 0, 4'b0000, 2'b00);
        step(1, 1, 0, 4'b0010, 2'b11);
        step(0, 0, 0, 4'b1010, 2'b00);
        // Allocation to an occupied slot is an error and sticks.
        step(1, 3, 0, 4'b0000, 2'b00);
        step(0, 0, 0, 4'b0000, 2'b00);
        step(0, 0, 0, 4'b1010, 2'b11);
        step(0, 0, 0, 4'b0000, 2'b00, 1);
        step(0, 0, 0, 4'b0000, 2'b00);
        // Flush with a simultaneous alloc drops the alloc.
        step(1, 0, 0, 4'b0000, 2'b00);
        step(1, 1, 0, 4'b0000, 2'b00);
        step(1, 2, 0, 4'b0000, 2'b00);
        step(1, 3, 1, 4'b0000, 2'b00);
        step(0, 0, 0, 4'b0000, 2'b00);
        // Oldest entry starved for five cycles, then flushed.
        step(1, 0, 0, 4'b0000, 2'b00);
        step(1, 1, 0, 4'b0000, 2'b00);
        repeat (5) step(0, 0, 0, 4'b0010, 2'b00);
        step(0, 0, 0, 4'b0000, 2'b00);
        step(0, 0, 1, 4'b0000, 2'b00);
        step(0, 0, 0, 4'b0000, 2'b00);

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            frees.delete();
            for (int s = 0; s < N; s++) if (!in_age(s)) frees.push_back(s);
            if (frees.size() > 0 && $urandom_range(0, 19) != 0)
                ai = frees[$urandom_range(0, frees.size() - 1)];
            else
                ai = $urandom_range(0, N - 1);
            step($urandom_range(0, 2) != 0, ai, $urandom_range(0, 49) == 0,
                 4'($urandom), 2'($urandom), $urandom_range(0, 299) == 0);
        end

        for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clk_i);
        @(negedge clk_i);
        n_chk++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL drain: %0d pending expectations, required 0", exp_q.size());
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
